// File: rtl/rom_window_sched.sv
// Shares the picture ROM between four windows: issues addresses LEAD clocks ahead of display.
// Latency: address 1 clk after act_x/act_y, win_valid/win_sel LEAD clks after; no backpressure.
module rom_window_sched #(
  parameter int X_BITS    = 12,
  parameter int Y_BITS    = 12,
  parameter int ADDR_BITS = 16,
  parameter int PIC_W     = 256,
  parameter int PIC_H     = 256,
  parameter int LEAD      = 11
) (
  input  logic                 pix_clk,
  input  logic                 rstn,
  input  logic                 vs_in,
  input  logic [X_BITS-1:0]    act_x,
  input  logic [Y_BITS-1:0]    act_y,
  input  logic                 cfg_wr,
  input  logic [1:0]           cfg_idx,
  input  logic [X_BITS-1:0]    cfg_x,
  input  logic [Y_BITS-1:0]    cfg_y,
  input  logic                 cfg_en,
  output logic                 cfg_ack,
  output logic                 rom_en,
  output logic [ADDR_BITS-1:0] rom_addr,
  output logic                 win_valid,
  output logic [1:0]           win_sel
);

  localparam int NUM_WIN = 4;
  localparam logic [X_BITS:0] LEAD_X = (X_BITS+1)'(LEAD);
  localparam logic [X_BITS:0] SPAN_X = (X_BITS+1)'(PIC_W - LEAD);
  localparam logic [Y_BITS:0] SPAN_Y = (Y_BITS+1)'(PIC_H);

  typedef enum logic [1:0] {WAIT_VS, COMMIT, ACTIVE} state_t;

  state_t               state;
  logic                 vs_q;
  logic                 vs_rise;
  logic [X_BITS-1:0]    sh_x  [NUM_WIN];
  logic [Y_BITS-1:0]    sh_y  [NUM_WIN];
  logic                 sh_en [NUM_WIN];
  logic [X_BITS-1:0]    win_x [NUM_WIN];
  logic [Y_BITS-1:0]    win_y [NUM_WIN];
  logic                 win_en[NUM_WIN];
  logic [ADDR_BITS-1:0] cnt   [NUM_WIN];
  logic [NUM_WIN-1:0]   in_win;
  logic                 fetch;
  logic [1:0]           hit_idx;
  logic [2:0]           pipe  [LEAD];

  assign vs_rise = vs_in & ~vs_q;

  // Bounds are one bit wider than the coordinates so hi/bottom edges never wrap.
  for (genvar g = 0; g < NUM_WIN; g++) begin : g_win
    logic [X_BITS:0] xe, lo, hi, ax;
    logic [Y_BITS:0] top, bot, ay;
    assign xe  = {1'b0, win_x[g]};
    assign lo  = (xe >= LEAD_X) ? xe - LEAD_X : '0;
    assign hi  = xe + SPAN_X;
    assign top = {1'b0, win_y[g]};
    assign bot = top + SPAN_Y;
    assign ax  = {1'b0, act_x};
    assign ay  = {1'b0, act_y};
    assign in_win[g] = win_en[g] && (ax >= lo) && (ax < hi) && (ay >= top) && (ay < bot);
  end

  // Descending scan so the lowest overlapping index ends up selected.
  always_comb begin
    hit_idx = '0;
    for (int i = NUM_WIN-1; i >= 0; i--) begin
      if (in_win[i]) hit_idx = 2'(i);
    end
  end

  assign fetch = (state == ACTIVE) && (|in_win);

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      state    <= WAIT_VS;
      vs_q     <= 1'b0;
      cfg_ack  <= 1'b0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
      for (int i = 0; i < NUM_WIN; i++) begin
        sh_x[i]   <= X_BITS'(256 + 384*i);
        sh_y[i]   <= Y_BITS'(412);
        sh_en[i]  <= 1'b1;
        win_x[i]  <= X_BITS'(256 + 384*i);
        win_y[i]  <= Y_BITS'(412);
        win_en[i] <= 1'b1;
        cnt[i]    <= '0;
      end
    end else begin
      vs_q    <= vs_in;
      cfg_ack <= cfg_wr;
      if (cfg_wr) begin
        sh_x[cfg_idx]  <= cfg_x;
        sh_y[cfg_idx]  <= cfg_y;
        sh_en[cfg_idx] <= cfg_en;
      end
      rom_en   <= fetch;
      rom_addr <= fetch ? cnt[hit_idx] : '0;
      if (fetch) cnt[hit_idx] <= cnt[hit_idx] + ADDR_BITS'(1);
      case (state)
        WAIT_VS: if (vs_rise) state <= COMMIT;
        COMMIT: begin
          // Reads the shadow before any same-cycle cfg_wr lands.
          for (int i = 0; i < NUM_WIN; i++) begin
            win_x[i]  <= sh_x[i];
            win_y[i]  <= sh_y[i];
            win_en[i] <= sh_en[i];
            cnt[i]    <= '0;
          end
          state <= ACTIVE;
        end
        ACTIVE:  if (vs_rise) state <= COMMIT;
        default: state <= WAIT_VS;
      endcase
    end
  end

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LEAD; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {fetch, fetch ? hit_idx : 2'd0};
      for (int i = 1; i < LEAD; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign win_valid = pipe[LEAD-1][2];
  assign win_sel   = pipe[LEAD-1][1:0];

endmodule

// File: tb/tb_rom_window_sched.sv
// Bench for rom_window_sched: scoreboard of address/display expectations plus directed spot checks.
module tb_rom_window_sched;
  localparam int LEAD = 11;

  logic        pix_clk = 1'b0;
  logic        rstn, vs_in, cfg_wr, cfg_en;
  logic [11:0] act_x, act_y, cfg_x, cfg_y;
  logic [1:0]  cfg_idx;
  logic        cfg_ack, rom_en, win_valid;
  logic [15:0] rom_addr;
  logic [1:0]  win_sel;

  always #5 pix_clk = ~pix_clk;

  rom_window_sched dut (
    .pix_clk(pix_clk), .rstn(rstn), .vs_in(vs_in), .act_x(act_x), .act_y(act_y),
    .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_en(cfg_en),
    .cfg_ack(cfg_ack), .rom_en(rom_en), .rom_addr(rom_addr),
    .win_valid(win_valid), .win_sel(win_sel)
  );

  int total = 0;
  int bad   = 0;
  logic [17:0] rom_q[$];
  logic [2:0]  disp_q[$];

  int   m_state;
  logic m_vsq;
  int   m_sx[4], m_sy[4], m_ax[4], m_ay[4], m_cnt[4];
  logic m_sen[4], m_aen[4];

  logic c_wr = 1'b0;
  int   c_idx = 0, c_x = 0, c_y = 0;
  logic c_en = 1'b0;

  logic        obs_ack, obs_en, obs_valid;
  logic [15:0] obs_addr;
  logic [1:0]  obs_sel;
  logic [16:0] rom_at[2048];
  logic [2:0]  disp_at[2048];
  int first_x, n_en, n_sel1;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_sx[i] = 256 + 384*i; m_sy[i] = 412; m_sen[i] = 1'b1;
      m_ax[i] = 256 + 384*i; m_ay[i] = 412; m_aen[i] = 1'b1;
      m_cnt[i] = 0;
    end
    m_state = 0;
    m_vsq   = 1'b0;
  endtask

  task automatic model_push(input logic vs, input int x, input int y);
    logic h;
    int w, lo, hi;
    h = 1'b0; w = 0;
    if (m_state == 2) begin
      for (int i = 0; i < 4; i++) begin
        if (!h && m_aen[i]) begin
          lo = (m_ax[i] >= LEAD) ? m_ax[i] - LEAD : 0;
          hi = m_ax[i] + 256 - LEAD;
          if (x >= lo && x < hi && y >= m_ay[i] && y < m_ay[i] + 256) begin
            h = 1'b1; w = i;
          end
        end
      end
    end
    rom_q.push_back({c_wr, h, h ? 16'(m_cnt[w]) : 16'd0});
    disp_q.push_back({h, h ? 2'(w) : 2'd0});
    if (h) m_cnt[w] = (m_cnt[w] + 1) % 65536;
    if (m_state == 1) begin
      for (int i = 0; i < 4; i++) begin
        m_ax[i] = m_sx[i]; m_ay[i] = m_sy[i]; m_aen[i] = m_sen[i]; m_cnt[i] = 0;
      end
      m_state = 2;
    end else if (vs && !m_vsq) begin
      m_state = 1;
    end
    if (c_wr) begin
      m_sx[c_idx] = c_x; m_sy[c_idx] = c_y; m_sen[c_idx] = c_en;
    end
    m_vsq = vs;
  endtask

  task automatic step(input logic vs, input int x, input int y);
    logic [17:0] e;
    logic [2:0]  d;
    @(negedge pix_clk);
    obs_ack = cfg_ack; obs_en = rom_en; obs_addr = rom_addr;
    obs_valid = win_valid; obs_sel = win_sel;
    e = (rom_q.size() > 0) ? rom_q.pop_front() : 18'h3ffff;
    d = (disp_q.size() > 0) ? disp_q.pop_front() : 3'b111;
    total++;
    if ({cfg_ack, rom_en, rom_addr} !== e) begin
      bad++;
      $display("FAIL rom_path x=%0d y=%0d got ack/en/addr=%0b/%0b/%0d exp=%0b/%0b/%0d",
               act_x, act_y, cfg_ack, rom_en, rom_addr, e[17], e[16], e[15:0]);
    end
    total++;
    if ({win_valid, win_sel} !== d) begin
      bad++;
      $display("FAIL display x=%0d y=%0d got valid/sel=%0b/%0d exp=%0b/%0d",
               act_x, act_y, win_valid, win_sel, d[2], d[1:0]);
    end
    vs_in = vs; act_x = 12'(x); act_y = 12'(y);
    cfg_wr = c_wr; cfg_idx = 2'(c_idx); cfg_x = 12'(c_x); cfg_y = 12'(c_y); cfg_en = c_en;
    model_push(vs, x, y);
    c_wr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge pix_clk);
    rstn = 1'b0; vs_in = 1'b0; act_x = '0; act_y = '0;
    cfg_wr = 1'b0; cfg_idx = '0; cfg_x = '0; cfg_y = '0; cfg_en = 1'b0;
    #1;
    total++;
    if ({cfg_ack, rom_en, rom_addr, win_valid, win_sel} !== 21'd0) begin
      bad++;
      $display("FAIL reset_async got ack/en/addr/valid/sel=%0b/%0b/%0d/%0b/%0d exp all 0",
               cfg_ack, rom_en, rom_addr, win_valid, win_sel);
    end
    repeat (3) @(negedge pix_clk);
    total++;
    if ({cfg_ack, rom_en, rom_addr, win_valid, win_sel} !== 21'd0) begin
      bad++;
      $display("FAIL reset_hold got ack/en/addr/valid/sel=%0b/%0b/%0d/%0b/%0d exp all 0",
               cfg_ack, rom_en, rom_addr, win_valid, win_sel);
    end
    model_reset();
    rom_q.delete(); disp_q.delete();
    repeat (LEAD-1) disp_q.push_back(3'b000);
    c_wr = 1'b0;
    rstn = 1'b1;
    model_push(1'b0, 0, 0);
  endtask

  // Frame start; with wr_in_commit the pending cfg write lands in the COMMIT clock.
  task automatic frame(input bit wr_in_commit);
    step(1'b1, 0, 0);
    if (wr_in_commit) c_wr = 1'b1;
    step(1'b1, 0, 0);
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
  endtask

  task automatic scan_line(input int y, input int x0, input int x1);
    for (int i = 0; i < 2048; i++) begin rom_at[i] = '0; disp_at[i] = '0; end
    first_x = -1; n_en = 0; n_sel1 = 0;
    for (int x = x0; x <= x1 + LEAD; x++) begin
      step(1'b0, x, y);
      if (x-1 >= x0 && x-1 <= x1) begin
        rom_at[x-1] = {obs_en, obs_addr};
        if (obs_en) n_en++;
        if (obs_en && first_x < 0) first_x = x-1;
      end
      if (x-LEAD >= x0 && x-LEAD <= x1) begin
        disp_at[x-LEAD] = {obs_valid, obs_sel};
        if (obs_valid && obs_sel == 2'd1) n_sel1++;
      end
    end
  endtask

  task automatic set_cfg(input int idx, input int x, input int y, input logic en);
    c_idx = idx; c_x = x; c_y = y; c_en = en;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (8) step(1'b0, 245, 412);
    total++;
    if (obs_en !== 1'b0) begin bad++; $display("FAIL no_fetch_before_vs got=%0b exp=0", obs_en); end
  endtask

  task automatic test_defaults();
    frame(1'b0);
    scan_line(412, 0, 1670);
    total++; if (first_x !== 245) begin bad++; $display("FAIL first_fetch_x got=%0d exp=245", first_x); end
    total++; if (rom_at[244] !== 17'h0) begin bad++; $display("FAIL pre_window got=%h exp=0", rom_at[244]); end
    total++; if (rom_at[245] !== 17'h10000) begin bad++; $display("FAIL w0_first got=%h exp=10000", rom_at[245]); end
    total++; if (rom_at[500] !== 17'h100ff) begin bad++; $display("FAIL w0_line_end got=%h exp=100ff", rom_at[500]); end
    total++; if (rom_at[501] !== 17'h0) begin bad++; $display("FAIL w0_past_hi got=%h exp=0", rom_at[501]); end
    total++; if (rom_at[629] !== 17'h10000) begin bad++; $display("FAIL w1_first got=%h exp=10000", rom_at[629]); end
    total++; if (n_en !== 1024) begin bad++; $display("FAIL line412_hits got=%0d exp=1024", n_en); end
    total++; if (disp_at[244] !== 3'b000) begin bad++; $display("FAIL disp_pre got=%b exp=000", disp_at[244]); end
    total++; if (disp_at[245] !== 3'b100) begin bad++; $display("FAIL disp_w0 got=%b exp=100", disp_at[245]); end
    total++; if (disp_at[629] !== 3'b101) begin bad++; $display("FAIL disp_w1 got=%b exp=101", disp_at[629]); end
    scan_line(413, 0, 700);
    total++; if (rom_at[245] !== 17'h10100) begin bad++; $display("FAIL w0_line413 got=%h exp=10100", rom_at[245]); end
    total++; if (rom_at[629] !== 17'h10100) begin bad++; $display("FAIL w1_line413 got=%h exp=10100", rom_at[629]); end
  endtask

  task automatic test_cfg_midframe();
    set_cfg(2, 100, 50, 1'b1);
    c_wr = 1'b1;
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
    total++; if (obs_ack !== 1'b1) begin bad++; $display("FAIL cfg_ack got=%0b exp=1", obs_ack); end
    scan_line(50, 0, 400);
    total++; if (n_en !== 0) begin bad++; $display("FAIL cfg_same_frame got=%0d exp=0", n_en); end
    frame(1'b0);
    scan_line(50, 0, 400);
    total++; if (first_x !== 89) begin bad++; $display("FAIL w2_first_x got=%0d exp=89", first_x); end
    total++; if (rom_at[89] !== 17'h10000) begin bad++; $display("FAIL w2_first got=%h exp=10000", rom_at[89]); end
    total++; if (rom_at[344] !== 17'h100ff) begin bad++; $display("FAIL w2_end got=%h exp=100ff", rom_at[344]); end
    total++; if (disp_at[89] !== 3'b110) begin bad++; $display("FAIL disp_w2 got=%b exp=110", disp_at[89]); end
  endtask

  task automatic test_low_x();
    set_cfg(1, 5, 412, 1'b1);
    c_wr = 1'b1;
    step(1'b0, 0, 0);
    frame(1'b0);
    scan_line(412, 0, 300);
    total++; if (rom_at[0] !== 17'h10000) begin bad++; $display("FAIL lowx_first got=%h exp=10000", rom_at[0]); end
    total++; if (disp_at[0] !== 3'b101) begin bad++; $display("FAIL lowx_disp got=%b exp=101", disp_at[0]); end
    total++; if (rom_at[244] !== 17'h100f4) begin bad++; $display("FAIL lowx_244 got=%h exp=100f4", rom_at[244]); end
    total++; if (rom_at[245] !== 17'h10000) begin bad++; $display("FAIL lowx_w0_wins got=%h exp=10000", rom_at[245]); end
    total++; if (rom_at[249] !== 17'h10004) begin bad++; $display("FAIL lowx_249 got=%h exp=10004", rom_at[249]); end
    total++; if (disp_at[249] !== 3'b100) begin bad++; $display("FAIL lowx_disp249 got=%b exp=100", disp_at[249]); end
  endtask

  task automatic test_overlap();
    set_cfg(1, 256, 412, 1'b1);
    c_wr = 1'b1;
    step(1'b0, 0, 0);
    frame(1'b0);
    scan_line(412, 0, 600);
    total++; if (n_sel1 !== 0) begin bad++; $display("FAIL overlap_sel1 got=%0d exp=0", n_sel1); end
    total++; if (n_en !== 256) begin bad++; $display("FAIL overlap_hits got=%0d exp=256", n_en); end
    total++; if (rom_at[500] !== 17'h100ff) begin bad++; $display("FAIL overlap_end got=%h exp=100ff", rom_at[500]); end
    total++; if (disp_at[300] !== 3'b100) begin bad++; $display("FAIL overlap_disp got=%b exp=100", disp_at[300]); end
    set_cfg(1, 900, 412, 1'b1);
    frame(1'b1);
    scan_line(412, 0, 1000);
    total++; if (rom_at[889] !== 17'h0) begin bad++; $display("FAIL commit_race_now got=%h exp=0", rom_at[889]); end
    total++; if (n_sel1 !== 0) begin bad++; $display("FAIL commit_race_sel got=%0d exp=0", n_sel1); end
    frame(1'b0);
    scan_line(412, 0, 1000);
    total++; if (rom_at[889] !== 17'h10000) begin bad++; $display("FAIL commit_race_next got=%h exp=10000", rom_at[889]); end
    total++; if (disp_at[889] !== 3'b101) begin bad++; $display("FAIL commit_race_disp got=%b exp=101", disp_at[889]); end
  endtask

  task automatic test_midframe_reset();
    scan_line(500, 240, 300);
    total++; if (n_en !== 56) begin bad++; $display("FAIL pre_reset_hits got=%0d exp=56", n_en); end
    do_reset();
    scan_line(500, 240, 300);
    total++; if (n_en !== 0) begin bad++; $display("FAIL post_reset_hits got=%0d exp=0", n_en); end
    frame(1'b0);
    scan_line(412, 0, 700);
    total++; if (rom_at[245] !== 17'h10000) begin bad++; $display("FAIL restart_w0 got=%h exp=10000", rom_at[245]); end
    total++; if (rom_at[629] !== 17'h10000) begin bad++; $display("FAIL restart_w1 got=%h exp=10000", rom_at[629]); end
  endtask

  initial begin
    rstn = 1'b1; vs_in = 1'b0; act_x = '0; act_y = '0;
    cfg_wr = 1'b0; cfg_idx = '0; cfg_x = '0; cfg_y = '0; cfg_en = 1'b0;
    test_reset();
    test_defaults();
    test_cfg_midframe();
    test_low_x();
    test_overlap();
    test_midframe_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
